// File: rtl/uart_pkg.sv
// uart_pkg: shared types and defaults for the UART library (uart_tx / uart_rx).
// Contents: receiver state enum, default oversampling/data-bit counts and a
// 2-of-3 majority helper used by the optional receive-side noise filter.
package uart_pkg;

    localparam int unsigned UART_OVERSAMPLING_DEF = 8;
    localparam int unsigned UART_DATA_BITS_DEF    = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_rx_state_t;

    // 2-of-3 vote over three line samples
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: parallel output bundle of the UART receiver.
// Signals: rx_data_out (last good word), rx_done_out (good-frame strobe),
// rx_busy_out (frame in progress), rx_frame_err_out (bad-stop-bit strobe).
// Modports: master = receiver side (drives), slave = consumer side (reads).
interface uart_rx_if
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS = UART_DATA_BITS_DEF
) ();

    logic [DATA_BITS-1:0] rx_data_out;
    logic                 rx_done_out;
    logic                 rx_busy_out;
    logic                 rx_frame_err_out;

    modport master (
        output rx_data_out,
        output rx_done_out,
        output rx_busy_out,
        output rx_frame_err_out
    );

    modport slave (
        input rx_data_out,
        input rx_done_out,
        input rx_busy_out,
        input rx_frame_err_out
    );

endinterface

// File: rtl/uart_sync.sv
// uart_sync: 2-FF synchronizer for an asynchronous single-bit input.
// Ports: clk_in, nrst_in (async active-low), d_in (async), q_out (synchronized).
// RST_VAL sets the value both flops take during reset.
module uart_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_in,
    input  logic nrst_in,
    input  logic d_in,
    output logic q_out
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_in;
            sync_q <= meta_q;
        end
    end

    assign q_out = sync_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampled asynchronous serial receiver (start, DATA_BITS LSB-first, 1 stop).
// Ports: clk_in (OVERSAMPLING x baud), nrst_in (async active-low),
//        rx_serial_in (idle-high line), rx_if (uart_rx_if.master outputs).
// Optional macro UART_RX_MAJORITY_EN: each sample point votes 2-of-3 over the
// current and two previous synchronized line values.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLING = UART_OVERSAMPLING_DEF,
    parameter int unsigned DATA_BITS    = UART_DATA_BITS_DEF
) (
    input  logic      clk_in,
    input  logic      nrst_in,
    input  logic      rx_serial_in,
    uart_rx_if.master rx_if
);

    localparam int unsigned CNT_W = $clog2(OVERSAMPLING);
    localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLING / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLING - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    uart_rx_state_t       state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 busy_q, busy_d;
    logic                 armed_q, armed_d;
    logic                 rx_s;
    logic                 sample_c;

    // Line synchronizer, idles high
    uart_sync #(.RST_VAL(1'b1)) u_sync (
        .clk_in  (clk_in),
        .nrst_in (nrst_in),
        .d_in    (rx_serial_in),
        .q_out   (rx_s)
    );

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_q;

    // Two previous synchronized samples for the majority vote
    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= {hist_q[0], rx_s};
        end
    end

    assign sample_c = maj3(rx_s, hist_q[0], hist_q[1]);
`else
    assign sample_c = rx_s;
`endif

    // State and output registers
    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            armed_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            armed_q <= armed_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        armed_d = armed_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                // Only a falling edge starts a frame: a held-low line must go high first
                if (rx_s) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    state_d = START;
                end
            end
            START: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_HALF) begin
                    if (sample_c) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end
                end
            end
            DATA: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    // Right shift so the first bit received lands in bit 0
                    shift_d = {sample_c, shift_q[DATA_BITS-1:1]};
                    idx_d   = idx_q + IDX_W'(1);
                    if (idx_q == IDX_LAST) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    // Leave at mid-stop-bit so an immediate next start edge is caught
                    state_d = IDLE;
                    cnt_d   = '0;
                    armed_d = 1'b0;
                    if (sample_c) begin
                        data_d = shift_q;
                        done_d = 1'b1;
                    end else begin
                        err_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign rx_if.rx_data_out      = data_q;
    assign rx_if.rx_done_out      = done_q;
    assign rx_if.rx_busy_out      = busy_q;
    assign rx_if.rx_frame_err_out = err_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx. A behavioural transmitter drives
// frames and queues the expected strobe (kind, word, cycle); a negedge monitor
// pops and compares whenever the receiver strobes done or frame error.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int unsigned OS = 8;
    localparam int unsigned DB = 8;
    // Strobe edge relative to the drive time of the start bit (edge k = cyc+1)
    localparam int STROBE_OFS = 3 + OS / 2 + (DB + 1) * OS;

    logic clk_in       = 1'b0;
    logic nrst_in      = 1'b0;
    logic rx_serial_in = 1'b1;

    always #5 clk_in = ~clk_in;

    uart_rx_if #(.DATA_BITS(DB)) rx_if ();

    uart_rx #(.OVERSAMPLING(OS), .DATA_BITS(DB)) dut (
        .clk_in       (clk_in),
        .nrst_in      (nrst_in),
        .rx_serial_in (rx_serial_in),
        .rx_if        (rx_if)
    );

    typedef struct {
        logic          is_err;
        logic [DB-1:0] data;
        int            cyc;
    } exp_t;

    exp_t          sb_q[$];
    int            cyc       = 0;
    int            errors    = 0;
    int            checks    = 0;
    logic [DB-1:0] last_good = '0;
    bit            lb_glitch = 1'b0;

    logic [7:0] b2b_vec[6] = '{8'h23, 8'h25, 8'hFF, 8'h00, 8'h01, 8'h80};
    logic [7:0] lb_vec[16] = '{8'h23, 8'h25, 8'hFF, 8'h00, 8'h01, 8'h80, 8'hA5, 8'h5A,
                               8'h3C, 8'hC3, 8'h0F, 8'hF0, 8'h55, 8'hAA, 8'h7E, 8'h10};

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe must match the head of the scoreboard
    always @(negedge clk_in) begin
        exp_t e;
        if (nrst_in && (rx_if.rx_done_out || rx_if.rx_frame_err_out)) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: done=%0b err=%0b data=0x%0h with nothing expected (cycle %0d)",
                         rx_if.rx_done_out, rx_if.rx_frame_err_out, rx_if.rx_data_out, cyc);
            end else begin
                e = sb_q.pop_front();
                check("strobe_err",   32'(rx_if.rx_frame_err_out), 32'(e.is_err));
                check("strobe_done",  32'(rx_if.rx_done_out),      32'(!e.is_err));
                check("strobe_data",  32'(rx_if.rx_data_out),      32'(e.data));
                check("strobe_cycle", cyc,                         e.cyc);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic idle(input int n);
        rx_serial_in = 1'b1;
        tick(n);
    endtask

    // One bit period; optional one-cycle inversion three edges before the sample edge
    task automatic drive_bit(input logic b, input bit glitch);
        for (int j = 0; j < int'(OS); j++) begin
            rx_serial_in = (glitch && j == int'(OS / 2)) ? ~b : b;
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic stop_bit, input bit glitch);
        exp_t e;
        if (stop_bit) last_good = d;
        e.is_err = !stop_bit;
        e.data   = last_good;
        e.cyc    = cyc + STROBE_OFS;
        sb_q.push_back(e);
        drive_bit(1'b0, glitch);
        for (int i = 0; i < int'(DB); i++) drive_bit(d[i], glitch);
        drive_bit(stop_bit, glitch);
    endtask

    task automatic wait_edge(input int e);
        while (cyc < e) @(negedge clk_in);
    endtask

    initial begin
        tick(3);
        check("rst_data", 32'(rx_if.rx_data_out),      32'h0);
        check("rst_done", 32'(rx_if.rx_done_out),      32'h0);
        check("rst_busy", 32'(rx_if.rx_busy_out),      32'h0);
        check("rst_err",  32'(rx_if.rx_frame_err_out), 32'h0);
        nrst_in = 1'b1;
        idle(10);

        // Single frame with busy window k+2..k+77
        fork
            send_frame(8'hA5, 1'b1, 1'b0);
            begin : busy_chk
                int k;
                k = cyc + 1;
                wait_edge(k + 1);  check("busy_k1",  32'(rx_if.rx_busy_out), 32'h0);
                wait_edge(k + 2);  check("busy_k2",  32'(rx_if.rx_busy_out), 32'h1);
                wait_edge(k + 77); check("busy_k77", 32'(rx_if.rx_busy_out), 32'h1);
                wait_edge(k + 78); check("busy_k78", 32'(rx_if.rx_busy_out), 32'h0);
            end
        join
        idle(8);
        check("hold_a5", 32'(rx_if.rx_data_out), 32'hA5);

        // Back-to-back stream
        foreach (b2b_vec[i]) send_frame(b2b_vec[i], 1'b1, 1'b0);
        idle(8);

        // Two-cycle glitch: START entered, then rejected at the start sample
        rx_serial_in = 1'b0;
        tick(2);
        rx_serial_in = 1'b1;
        tick(2);
        check("glitch_busy_hi", 32'(rx_if.rx_busy_out), 32'h1);
        tick(4);
        check("glitch_busy_lo", 32'(rx_if.rx_busy_out), 32'h0);
        idle(8);
        send_frame(8'h3C, 1'b1, 1'b0);
        idle(8);

        // Framing error followed by a break
        send_frame(8'h55, 1'b0, 1'b0);
        rx_serial_in = 1'b0;
        tick(20 * int'(OS));
        check("break_busy", 32'(rx_if.rx_busy_out), 32'h0);
        check("break_data", 32'(rx_if.rx_data_out), 32'h3C);
        idle(16);
        send_frame(8'h0F, 1'b1, 1'b0);
        idle(8);

        // Reset during data bit 3 of 0x5A
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b0, 1'b0);
        rx_serial_in = 1'b1;
        tick(int'(OS / 2));
        check("mid_busy", 32'(rx_if.rx_busy_out), 32'h1);
        nrst_in = 1'b0;
        #1;
        check("mrst_data", 32'(rx_if.rx_data_out),      32'h0);
        check("mrst_done", 32'(rx_if.rx_done_out),      32'h0);
        check("mrst_busy", 32'(rx_if.rx_busy_out),      32'h0);
        check("mrst_err",  32'(rx_if.rx_frame_err_out), 32'h0);
        last_good = '0;
        tick(3);
        nrst_in = 1'b1;
        idle(8);
        send_frame(8'h99, 1'b1, 1'b0);
        idle(8);

        // Loopback stream; with the majority filter every sample point is disturbed
`ifdef UART_RX_MAJORITY_EN
        lb_glitch = 1'b1;
`else
        lb_glitch = 1'b0;
`endif
        foreach (lb_vec[i]) send_frame(lb_vec[i], 1'b1, lb_glitch);
        idle(16);
        check("lb_last", 32'(rx_if.rx_data_out), 32'h10);
        check("sb_drained", 32'(sb_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver, the receive-side counterpart of `uart_tx`, in the UART library. It samples `rx_serial_in` on a clock running at `OVERSAMPLING` × baud and deserialises 8N1-style frames: start bit, `DATA_BITS` data bits LSB-first, one stop bit. Each completed frame is presented as a parallel word with a one-cycle done strobe, or flagged as a framing error. The block is driven from the same oversampled clock as `uart_tx`, so the two can be looped back directly.

## Interface
- `OVERSAMPLING`, default 8: clock cycles per bit. Must be even and ≥ 4.
- `DATA_BITS`, default 8: data bits per frame, 5..9.

- `clk_in`, input, 1: oversampled clock (`OVERSAMPLING` × baud).
- `nrst_in`, input, 1: asynchronous, active-low reset.
- `rx_serial_in`, input, 1: serial line, idle high, asynchronous to `clk_in`.
- `rx_data_out`, output, `DATA_BITS`: last good word. Held until the next good frame.
- `rx_done_out`, output, 1: one-cycle pulse when a frame with a valid stop bit completes.
- `rx_busy_out`, output, 1: high while a frame is in progress (every state except IDLE).
- `rx_frame_err_out`, output, 1: one-cycle pulse when the stop bit is sampled low.

## Operation
- **Input synchronizer.** A 2-FF synchronizer on `rx_serial_in` produces `rx_s`. Both flops reset to 1.
- **States.** IDLE, START, DATA, STOP. A cycle counter `cnt` (width clog2(`OVERSAMPLING`)) and a bit index `bit_idx` (width clog2(`DATA_BITS`+1)).
- **IDLE.**
  - If `rx_s`==0: go to START with `cnt`=0.
- **START.**
  - `cnt` increments each cycle.
  - At `cnt`==`OVERSAMPLING`/2−1, sample the line.
    - Sample 1 (glitch): return to IDLE. No strobe.
    - Sample 0: go to DATA with `cnt`=0 and `bit_idx`=0.
- **DATA.**
  - `cnt` increments each cycle and wraps at `OVERSAMPLING`−1.
  - At the wrap, the sample is shifted in at the MSB of a right-shifting register, so the first-received bit ends up at bit 0. `bit_idx` then increments.
  - After `DATA_BITS` samples, go to STOP with `cnt`=0.
- **STOP.** At `cnt`==`OVERSAMPLING`−1, sample the line and go to IDLE.
  - Sample 1: load `rx_data_out` from the shift register and pulse `rx_done_out`.
  - Sample 0: pulse `rx_frame_err_out`. `rx_data_out` is unchanged.
- **Back-to-back frames.** Because IDLE is re-entered at mid-stop-bit, a start bit that follows immediately is detected without loss.
- **Break condition.** A line held low is a framing error. After it, the receiver stays in IDLE until `rx_s` returns high, then waits for a falling edge.
  - Falling-edge arming is required: IDLE may transition only after `rx_s` has been seen high at least once since the last frame or reset.
- **Reset values.**
  - `rx_data_out` = 0, `rx_done_out` = 0, `rx_busy_out` = 0, `rx_frame_err_out` = 0.
  - State = IDLE, counters = 0, synchronizer = 1, armed = 1.
- **Reset mid-frame.** The frame is abandoned immediately with no strobe. Sampling restarts at the next falling edge after reset release.

## Timing
- **Start detection.** Let edge k be the first clock edge at which `rx_serial_in` is low.
  - `rx_s` is low after edge k+1.
  - START is entered at edge k+2.
- **Sample points.**
  - Start sample: edge k+2+`OVERSAMPLING`/2.
  - Data bit i: edge k+2+`OVERSAMPLING`/2+(i+1)·`OVERSAMPLING`.
  - Stop sample: edge k+2+`OVERSAMPLING`/2+(`DATA_BITS`+1)·`OVERSAMPLING`.
- **Outputs.**
  - `rx_done_out` / `rx_frame_err_out` are registered at the stop-sample edge and high for exactly one cycle.
  - For the defaults (8, 8) the strobe comes 78 cycles after edge k.
  - `rx_busy_out` rises at edge k+2 and falls at the same edge the strobe rises.
- **Tolerance.** Baud mismatch up to ±(`OVERSAMPLING`/2−1)/(`OVERSAMPLING`·(`DATA_BITS`+1.5)) is tolerated.

## Configuration
- **`UART_RX_MAJORITY_EN` defined.**
  - Every sample point (start, data, stop) uses the 2-of-3 majority of `rx_s` at that edge and the two preceding edges.
  - A 2-bit history register is added.
  - Timing of all strobes is unchanged.
- **`UART_RX_MAJORITY_EN` undefined.** A single `rx_s` sample is used and the history register is absent.

## Structure
- **`uart_pkg`.** Holds the `uart_rx_state_t` enum (IDLE, START, DATA, STOP) and the defaults `UART_OVERSAMPLING_DEF` = 8 and `UART_DATA_BITS_DEF` = 8. The package is shared with `uart_tx`.
- **Sub-module `uart_sync`.** 2-FF synchronizer with a reset-value parameter `RST_VAL` (default 1), reusable across the library.

## Test plan
- **Single frame.** Reset, then drive the frame for 0xA5 with 8 cycles per bit. Expect `rx_data_out`==0xA5, one `rx_done_out` pulse 78 cycles after the falling edge, and `rx_busy_out` high for edges k+2..k+77.
- **Back-to-back stream.** Send 0x23, 0x25, 0xFF, 0x00, 0x01, 0x80 with no idle between frames. Expect six done pulses, matching words in order, and no frame errors.
- **Glitch rejection.** Pulse the line low for 2 cycles, then high. Expect no strobe, `rx_busy_out` back to 0 within 6 cycles, and a following frame 0x3C received correctly.
- **Framing error.** Send 0x55 with the stop bit low, then hold the line low for 20 bit-times. Expect exactly one `rx_frame_err_out`, `rx_data_out` unchanged, and no further activity until the line returns high. The next frame 0x0F is then received.
- **Reset mid-frame.** Assert `nrst_in` during data bit 3. Expect all outputs 0 at once and no strobe. A frame 0x99 after release is received correctly.
- **Loopback (both macro settings).** Connect `uart_tx` → `uart_rx` and send 16 vectors (0x23 … 0x10). Expect all 16 match. With `UART_RX_MAJORITY_EN` defined, additionally inject a one-cycle inverted glitch at every sample point and expect all words to still match.
